// File: rtl/gtfmac_bitslip_supervisor.sv
// gtfmac_bitslip_supervisor
// Sequences one GTFMAC bitslip adjustment block through bring-up:
// reset -> wait for block lock -> trigger correction -> confirm relock -> UP.
// Failed attempts re-reset the bitslip block, up to MAX_RETRY attempts.
// Once UP, a sustained loss of block lock restarts the sequence.
// Optional build macro GTFMAC_BS_SUP_STATS_EN adds lock_loss_cnt and
// last_fail_cause status outputs.
module gtfmac_bitslip_supervisor #(
  parameter int                CNT_W        = 20,
  parameter logic [CNT_W-1:0]  LOCK_TIMEOUT = 20'hFFFFF,
  parameter logic [CNT_W-1:0]  CORR_TIMEOUT = 20'h00FFF,
  parameter int                RST_CYCLES   = 16,
  parameter int                LOSS_FILTER  = 16,
  parameter int                MAX_RETRY    = 3
) (
  input  logic       rx_clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx_block_lock,
  input  logic       bs_locked,
  input  logic       bs_busy,
  input  logic       bs_done,
  input  logic       bs_excessive,
  output logic       bs_rst,
  output logic       bs_correct,
  output logic       link_up,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] sup_state,
  output logic       timeout_pulse
`ifdef GTFMAC_BS_SUP_STATS_EN
  ,
  output logic [7:0] lock_loss_cnt,
  output logic [1:0] last_fail_cause
`endif
);

  localparam int               FILT_W    = $clog2(LOSS_FILTER + 1);
  localparam logic [FILT_W-1:0] FILT_LIM = FILT_W'(LOSS_FILTER);
  localparam logic [CNT_W-1:0]  RST_LIM  = CNT_W'(RST_CYCLES);
  localparam logic [3:0]        RETRY_LIM = 4'(MAX_RETRY);

  // Error causes; 2'd0 means no error.
  localparam logic [1:0] CAUSE_LOCK_TO = 2'd1;
  localparam logic [1:0] CAUSE_CORR_TO = 2'd2;
  localparam logic [1:0] CAUSE_EXCESS  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_RST         = 3'd1,
    S_WAIT_LOCK   = 3'd2,
    S_CORRECT     = 3'd3,
    S_WAIT_DONE   = 3'd4,
    S_WAIT_RELOCK = 3'd5,
    S_UP          = 3'd6,
    S_FAIL        = 3'd7
  } state_t;

  state_t            state_r, state_nx_s;
  logic [CNT_W-1:0]  timer_r, timer_inc_s, timer_nx_s;
  logic [FILT_W-1:0] filt_r, filt_inc_s, filt_nx_s;
  logic [3:0]        retry_nx_s;
  logic              keep_timer_s;
  logic              err_s;
  logic [1:0]        err_cause_s;
  logic              err_timeout_s;

  // Saturating increments of the shared timer and the lock filter.
  always_comb begin
    if (timer_r == {CNT_W{1'b1}}) begin
      timer_inc_s = timer_r;
    end else begin
      timer_inc_s = timer_r + CNT_W'(1);
    end
    if (filt_r == {FILT_W{1'b1}}) begin
      filt_inc_s = filt_r;
    end else begin
      filt_inc_s = filt_r + FILT_W'(1);
    end
  end

  // Next-state, retry and error decision; enable=0 overrides everything.
  always_comb begin
    state_nx_s   = state_r;
    retry_nx_s   = retry_cnt;
    keep_timer_s = 1'b0;
    err_s        = 1'b0;
    err_cause_s  = 2'd0;
    if (!enable) begin
      state_nx_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_nx_s = S_RST;
          retry_nx_s = 4'd0;
        end
        S_RST: begin
          if (timer_inc_s >= RST_LIM) begin
            state_nx_s = S_WAIT_LOCK;
          end else begin
            state_nx_s = S_RST;
          end
        end
        S_WAIT_LOCK: begin
          if (bs_excessive) begin
            err_s       = 1'b1;
            err_cause_s = CAUSE_EXCESS;
          end else if (bs_done) begin
            state_nx_s = S_WAIT_RELOCK;   // 25G path: no correction needed
          end else if (bs_locked) begin
            state_nx_s = S_CORRECT;
          end else if (timer_inc_s >= LOCK_TIMEOUT) begin
            err_s       = 1'b1;
            err_cause_s = CAUSE_LOCK_TO;
          end else begin
            state_nx_s = S_WAIT_LOCK;
          end
        end
        S_CORRECT: begin
          if (bs_busy || bs_done) begin
            state_nx_s   = S_WAIT_DONE;
            keep_timer_s = 1'b1;          // correction budget spans both states
          end else if (timer_inc_s >= CORR_TIMEOUT) begin
            err_s       = 1'b1;
            err_cause_s = CAUSE_CORR_TO;
          end else begin
            state_nx_s = S_CORRECT;
          end
        end
        S_WAIT_DONE: begin
          if (bs_done) begin
            state_nx_s = S_WAIT_RELOCK;
          end else if (timer_inc_s >= CORR_TIMEOUT) begin
            err_s       = 1'b1;
            err_cause_s = CAUSE_CORR_TO;
          end else begin
            state_nx_s = S_WAIT_DONE;
          end
        end
        S_WAIT_RELOCK: begin
          if (rx_block_lock && (filt_inc_s >= FILT_LIM)) begin
            state_nx_s = S_UP;
            retry_nx_s = 4'd0;
          end else if (timer_inc_s >= LOCK_TIMEOUT) begin
            err_s       = 1'b1;
            err_cause_s = CAUSE_LOCK_TO;
          end else begin
            state_nx_s = S_WAIT_RELOCK;
          end
        end
        S_UP: begin
          if (!rx_block_lock && (filt_inc_s >= FILT_LIM)) begin
            state_nx_s = S_RST;
          end else begin
            state_nx_s = S_UP;
          end
        end
        S_FAIL: begin
          state_nx_s = S_FAIL;
        end
        default: begin
          state_nx_s = S_IDLE;
        end
      endcase
      if (err_s) begin
        retry_nx_s = retry_cnt + 4'd1;
        if (retry_nx_s >= RETRY_LIM) begin
          state_nx_s = S_FAIL;
        end else begin
          state_nx_s = S_RST;
        end
      end else begin
        retry_nx_s = retry_nx_s;
      end
    end
  end

  assign err_timeout_s = err_s && (err_cause_s != CAUSE_EXCESS);

  // Timer clears on state entry (except CORRECT->WAIT_DONE); filter counts
  // lock-high in WAIT_RELOCK and lock-low in UP, clearing on the other level.
  always_comb begin
    if ((state_nx_s != state_r) && !keep_timer_s) begin
      timer_nx_s = {CNT_W{1'b0}};
    end else begin
      timer_nx_s = timer_inc_s;
    end
    if (state_nx_s != state_r) begin
      filt_nx_s = {FILT_W{1'b0}};
    end else if ((state_r == S_WAIT_RELOCK) && rx_block_lock) begin
      filt_nx_s = filt_inc_s;
    end else if ((state_r == S_UP) && !rx_block_lock) begin
      filt_nx_s = filt_inc_s;
    end else begin
      filt_nx_s = {FILT_W{1'b0}};
    end
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge rx_clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      timer_r       <= {CNT_W{1'b0}};
      filt_r        <= {FILT_W{1'b0}};
      retry_cnt     <= 4'd0;
      bs_rst        <= 1'b1;
      bs_correct    <= 1'b0;
      link_up       <= 1'b0;
      fail          <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      timer_r       <= timer_nx_s;
      filt_r        <= filt_nx_s;
      retry_cnt     <= retry_nx_s;
      bs_rst        <= (state_nx_s == S_IDLE) || (state_nx_s == S_RST) || (state_nx_s == S_FAIL);
      bs_correct    <= (state_nx_s == S_CORRECT) || (state_nx_s == S_WAIT_DONE);
      link_up       <= (state_nx_s == S_UP);
      fail          <= (state_nx_s == S_FAIL);
      timeout_pulse <= err_timeout_s;
    end
  end

  assign sup_state = state_r;

`ifdef GTFMAC_BS_SUP_STATS_EN
  // Lock-loss event counter and cause of the most recent failed attempt.
  always_ff @(posedge rx_clk or negedge reset) begin
    if (!reset) begin
      lock_loss_cnt   <= 8'd0;
      last_fail_cause <= 2'd0;
    end else begin
      if ((state_r == S_UP) && (state_nx_s == S_RST) && (lock_loss_cnt != 8'hFF)) begin
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
      end
      if (err_s) begin
        last_fail_cause <= err_cause_s;
      end else if ((state_r == S_IDLE) && (state_nx_s == S_RST)) begin
        last_fail_cause <= 2'd0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gtfmac_bitslip_supervisor.sv
// Scoreboard bench for gtfmac_bitslip_supervisor. Stimulus pushes the
// expected state-transition records; a negedge monitor pops one per observed
// sup_state change and compares outputs and time spent in the previous state.
module tb_gtfmac_bitslip_supervisor;

  localparam logic [2:0] S_IDLE = 3'd0, S_RST = 3'd1, S_WL = 3'd2, S_CORR = 3'd3;
  localparam logic [2:0] S_WDONE = 3'd4, S_RELOCK = 3'd5, S_UP = 3'd6, S_FAIL = 3'd7;

  logic rx_clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic rx_block_lock = 1'b0;
  logic bs_locked = 1'b0;
  logic bs_busy = 1'b0;
  logic bs_done = 1'b0;
  logic bs_excessive = 1'b0;
  logic bs_rst, bs_correct, link_up, fail, timeout_pulse;
  logic [3:0] retry_cnt;
  logic [2:0] sup_state;
`ifdef GTFMAC_BS_SUP_STATS_EN
  logic [7:0] lock_loss_cnt;
  logic [1:0] last_fail_cause;
`endif

  gtfmac_bitslip_supervisor #(
    .CNT_W(20), .LOCK_TIMEOUT(20'd1000), .CORR_TIMEOUT(20'd200),
    .RST_CYCLES(16), .LOSS_FILTER(16), .MAX_RETRY(3)
  ) dut (
    .rx_clk(rx_clk), .reset(reset), .enable(enable), .rx_block_lock(rx_block_lock),
    .bs_locked(bs_locked), .bs_busy(bs_busy), .bs_done(bs_done), .bs_excessive(bs_excessive),
    .bs_rst(bs_rst), .bs_correct(bs_correct), .link_up(link_up), .fail(fail),
    .retry_cnt(retry_cnt), .sup_state(sup_state), .timeout_pulse(timeout_pulse)
`ifdef GTFMAC_BS_SUP_STATS_EN
    , .lock_loss_cnt(lock_loss_cnt), .last_fail_cause(last_fail_cause)
`endif
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       rst;
    logic       corr;
    logic       up;
    logic       fl;
    logic [3:0] rc;
    logic       tp;
    int         dur;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int run_len = 0;
  logic [2:0] prev_st = 3'd0;
  int tp_cycles = 0;
  int corr_cycles = 0;
  int snap;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input string tag, input logic [2:0] st, input logic rst, input logic corr,
                      input logic up, input logic fl, input logic [3:0] rc, input logic tp,
                      input int dur);
    exp_t e;
    e.tag = tag; e.st = st; e.rst = rst; e.corr = corr; e.up = up;
    e.fl = fl; e.rc = rc; e.tp = tp; e.dur = dur;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge rx_clk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int n;
    n = 0;
    while ((sup_state != st) && (n < budget)) begin
      @(posedge rx_clk);
      #1;
      n++;
    end
    chk({"wait_", tag}, sup_state, st);
  endtask

  // Monitor: on every state change pop and compare the next expected record.
  always @(negedge rx_clk) begin
    if (timeout_pulse) tp_cycles <= tp_cycles + 1;
    if (bs_correct) corr_cycles <= corr_cycles + 1;
    if (sup_state != prev_st) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_transition: got state %0d from %0d, expected no change",
                 sup_state, prev_st);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.tag, ".state"}, sup_state, mon_e.st);
        chk({mon_e.tag, ".bs_rst"}, bs_rst, mon_e.rst);
        chk({mon_e.tag, ".bs_correct"}, bs_correct, mon_e.corr);
        chk({mon_e.tag, ".link_up"}, link_up, mon_e.up);
        chk({mon_e.tag, ".fail"}, fail, mon_e.fl);
        chk({mon_e.tag, ".retry_cnt"}, retry_cnt, mon_e.rc);
        chk({mon_e.tag, ".timeout_pulse"}, timeout_pulse, mon_e.tp);
        if (mon_e.dur >= 0) chk({mon_e.tag, ".cycles_prev"}, run_len, mon_e.dur);
      end
      prev_st <= sup_state;
      run_len <= 1;
    end else begin
      run_len <= run_len + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    @(posedge rx_clk);
    #1;
    chk("rst.bs_rst", bs_rst, 1);
    chk("rst.bs_correct", bs_correct, 0);
    chk("rst.link_up", link_up, 0);
    chk("rst.fail", fail, 0);
    chk("rst.retry_cnt", retry_cnt, 0);
    chk("rst.sup_state", sup_state, 0);
    chk("rst.timeout_pulse", timeout_pulse, 0);
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(2);

    // Normal 10G bring-up
    push("s1_rst", S_RST, 1, 0, 0, 0, 0, 0, -1);
    push("s1_wl", S_WL, 0, 0, 0, 0, 0, 0, 16);
    push("s1_corr", S_CORR, 0, 1, 0, 0, 0, 0, 51);
    push("s1_wdone", S_WDONE, 0, 1, 0, 0, 0, 0, 4);
    push("s1_relock", S_RELOCK, 0, 0, 0, 0, 0, 0, 41);
    push("s1_up", S_UP, 0, 0, 1, 0, 0, 0, 16);
    snap = corr_cycles;
    rx_block_lock = 1'b1;
    enable = 1'b1;
    wait_state(S_WL, 100, "s1_wl");
    wait_cycles(50);  bs_locked = 1'b1;
    wait_cycles(4);   bs_busy = 1'b1;
    wait_cycles(41);  bs_done = 1'b1; bs_busy = 1'b0;
    wait_cycles(1);   bs_done = 1'b0; bs_locked = 1'b0;
    wait_state(S_UP, 100, "s1_up");
    chk("s1.bs_correct_cycles", corr_cycles - snap, 45);

    // Lock loss in UP: 15-cycle drop ignored, 16-cycle drop restarts
    push("s5_rst", S_RST, 1, 0, 0, 0, 0, 0, 36);
    push("s5_wl", S_WL, 0, 0, 0, 0, 0, 0, 16);
    rx_block_lock = 1'b0;
    wait_cycles(15);  rx_block_lock = 1'b1;
    wait_cycles(5);   rx_block_lock = 1'b0;
    wait_state(S_RST, 50, "s5_rst");
    rx_block_lock = 1'b1;
`ifdef GTFMAC_BS_SUP_STATS_EN
    chk("s5.lock_loss_cnt", lock_loss_cnt, 1);
`endif

    // 25G path: bs_done with bs_locked in WAIT_LOCK skips correction
    push("s2_relock", S_RELOCK, 0, 0, 0, 0, 0, 0, 11);
    push("s2_up", S_UP, 0, 0, 1, 0, 0, 0, 16);
    wait_state(S_WL, 50, "s2_wl");
    snap = corr_cycles;
    wait_cycles(10);  bs_done = 1'b1; bs_locked = 1'b1;
    wait_cycles(1);   bs_done = 1'b0; bs_locked = 1'b0;
    wait_state(S_UP, 100, "s2_up");
    chk("s2.bs_correct_cycles", corr_cycles - snap, 0);

    // Lock timeout three times -> FAIL
    push("s3_idle", S_IDLE, 1, 0, 0, 0, 0, 0, 1);
    push("s3_rst0", S_RST, 1, 0, 0, 0, 0, 0, 3);
    push("s3_wl0", S_WL, 0, 0, 0, 0, 0, 0, 16);
    push("s3_rst1", S_RST, 1, 0, 0, 0, 1, 1, 1000);
    push("s3_wl1", S_WL, 0, 0, 0, 0, 1, 0, 16);
    push("s3_rst2", S_RST, 1, 0, 0, 0, 2, 1, 1000);
    push("s3_wl2", S_WL, 0, 0, 0, 0, 2, 0, 16);
    push("s3_fail", S_FAIL, 1, 0, 0, 1, 3, 1, 1000);
    enable = 1'b0;
    rx_block_lock = 1'b0;
    wait_cycles(3);   enable = 1'b1;
    wait_state(S_FAIL, 4000, "s3_fail");
`ifdef GTFMAC_BS_SUP_STATS_EN
    chk("s3.last_fail_cause", last_fail_cause, 1);
`endif

    // enable=0 in FAIL -> IDLE
    push("s3_exit", S_IDLE, 1, 0, 0, 0, 3, 0, 6);
    wait_cycles(5);   enable = 1'b0;

    // Excessive bitslip in WAIT_LOCK -> retry without timeout pulse
    push("s4_rst0", S_RST, 1, 0, 0, 0, 0, 0, 2);
    push("s4_wl0", S_WL, 0, 0, 0, 0, 0, 0, 16);
    push("s4_rst1", S_RST, 1, 0, 0, 0, 1, 0, 6);
    push("s4_wl1", S_WL, 0, 0, 0, 0, 1, 0, 16);
    wait_cycles(2);   enable = 1'b1;
    wait_state(S_WL, 50, "s4_wl");
    wait_cycles(5);   bs_excessive = 1'b1;
    wait_state(S_RST, 20, "s4_rst");
    bs_excessive = 1'b0;
`ifdef GTFMAC_BS_SUP_STATS_EN
    chk("s4.last_fail_cause", last_fail_cause, 3);
`endif

    // Async reset in the middle of WAIT_DONE
    push("s6_corr", S_CORR, 0, 1, 0, 0, 1, 0, 1);
    push("s6_wdone", S_WDONE, 0, 1, 0, 0, 1, 0, 1);
    push("s6_reset", S_IDLE, 1, 0, 0, 0, 0, 0, -1);
    wait_state(S_WL, 50, "s6_wl");
    bs_locked = 1'b1;
    bs_busy = 1'b1;
    wait_state(S_WDONE, 20, "s6_wdone");
    wait_cycles(3);
    #2;
    reset = 1'b0;
    #1;
    chk("s6.bs_rst", bs_rst, 1);
    chk("s6.bs_correct", bs_correct, 0);
    chk("s6.sup_state", sup_state, 0);
    chk("s6.retry_cnt", retry_cnt, 0);
    bs_locked = 1'b0;
    bs_busy = 1'b0;
    enable = 1'b0;
    @(posedge rx_clk);
    #1;
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(2);

    // Correction timeout: budget shared by CORRECT and WAIT_DONE
    push("s7_rst", S_RST, 1, 0, 0, 0, 0, 0, -1);
    push("s7_wl", S_WL, 0, 0, 0, 0, 0, 0, 16);
    push("s7_corr", S_CORR, 0, 1, 0, 0, 0, 0, 1);
    push("s7_wdone", S_WDONE, 0, 1, 0, 0, 0, 0, 50);
    push("s7_rst1", S_RST, 1, 0, 0, 0, 1, 1, 150);
    push("s7_wl1", S_WL, 0, 0, 0, 0, 1, 0, 16);
    push("s7_idle", S_IDLE, 1, 0, 0, 0, 1, 0, 1);
    enable = 1'b1;
    wait_state(S_WL, 50, "s7_wl");
    snap = corr_cycles;
    bs_locked = 1'b1;
    wait_state(S_CORR, 10, "s7_corr");
    wait_cycles(49);  bs_busy = 1'b1;
    wait_state(S_RST, 300, "s7_rst");
    bs_locked = 1'b0;
    bs_busy = 1'b0;
    chk("s7.bs_correct_cycles", corr_cycles - snap, 200);
`ifdef GTFMAC_BS_SUP_STATS_EN
    chk("s7.last_fail_cause", last_fail_cause, 2);
`endif
    wait_state(S_WL, 50, "s7_wl1");
    enable = 1'b0;
    wait_cycles(4);

    chk("timeout_pulse_cycles", tp_cycles, 4);
    chk("expected_left", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gtfmac_bitslip_supervisor.md
Name: gtfmac_bitslip_supervisor

Overview:
Sequencing controller for the GTFMAC bitslip adjustment block on one channel.
- Holds the bitslip block in reset, releases it, waits for block lock, then triggers bitslip correction.
- Confirms block lock re-acquires after the gearbox resync.
- On timeout or excessive bitslip, retries by re-resetting the bitslip block, up to a bounded count.
- After link-up, monitors lock loss and restarts the sequence. Sits between channel reset/bring-up logic and the bitslip block's ctl_*/stat_* pins.

Parameters:
- CNT_W, 20, width of the shared timeout counter.
- LOCK_TIMEOUT, 20'hFFFFF, cycles allowed in WAIT_LOCK and WAIT_RELOCK.
- CORR_TIMEOUT, 20'h00FFF, cycles allowed in CORRECT plus WAIT_DONE, combined.
- RST_CYCLES, 16, cycles bs_rst is held high in RST.
- LOSS_FILTER, 16, consecutive cycles rx_block_lock must be low (in UP) or high (in WAIT_RELOCK) to count.
- MAX_RETRY, 3, failed attempts before FAIL. Range 1..15.

Ports:
- rx_clk  in  1  clock
- reset  in  1  async active-low reset
- enable  in  1  synchronous to rx_clk. 1 = run bring-up; 0 = return to IDLE.
- rx_block_lock  in  1  raw GTFMAC block lock (gtf_ch_statrxblocklock)
- bs_locked  in  1  bitslip block stat_locked
- bs_busy  in  1  bitslip block stat_busy
- bs_done  in  1  bitslip block stat_done
- bs_excessive  in  1  bitslip block stat_excessive_bitslip
- bs_rst  out  1  active-high reset to the bitslip block (its rx_rst)
- bs_correct  out  1  to the bitslip block ctl_correct_bitslip
- link_up  out  1  registered; 1 only in UP
- fail  out  1  registered; 1 only in FAIL
- retry_cnt  out  4  failed attempts in the current bring-up
- sup_state  out  3  encoded current state
- timeout_pulse  out  1  one-cycle pulse on any timeout

Behaviour:
- Reset, clocking and outputs:
  - reset reset, asynchronous, active-low; clock rx_clk.
  - All flops are asynchronously cleared by reset. All outputs are registered.
  - Reset values: bs_rst=1, bs_correct=0, link_up=0, fail=0, retry_cnt=0, sup_state=IDLE, timeout_pulse=0.
- State encoding: IDLE=0, RST=1, WAIT_LOCK=2, CORRECT=3, WAIT_DONE=4, WAIT_RELOCK=5, UP=6, FAIL=7.
- Global rule: enable=0 in any state -> IDLE next cycle, bs_rst=1, bs_correct=0. This has priority over all other transitions.
- IDLE: bs_rst=1. On enable=1 -> RST, retry_cnt=0.
- RST: bs_rst=1 for RST_CYCLES cycles, then -> WAIT_LOCK with bs_rst=0 and timer cleared.
- WAIT_LOCK (checks in priority order):
  1. bs_excessive=1 -> ERR.
  2. bs_done=1 -> WAIT_RELOCK. This is the 25G path; no correction is needed.
  3. bs_locked=1 -> CORRECT.
  4. Timer reaches LOCK_TIMEOUT -> ERR.
- CORRECT: bs_correct=1, held because the bitslip block synchronises this input through 3 flops.
  - bs_busy=1 or bs_done=1 -> WAIT_DONE, bs_correct stays 1.
  - Timer reaches CORR_TIMEOUT -> ERR.
- WAIT_DONE:
  - bs_done=1 -> WAIT_RELOCK, bs_correct=0.
  - The timer continues from CORRECT (not cleared); reaching CORR_TIMEOUT -> ERR.
- WAIT_RELOCK:
  - Filter counter increments while rx_block_lock=1 and clears to 0 when rx_block_lock=0.
  - Filter count reaches LOSS_FILTER -> UP, retry_cnt=0.
  - Timer reaches LOCK_TIMEOUT -> ERR.
- UP: link_up=1. rx_block_lock low for LOSS_FILTER consecutive cycles -> RST; link_up drops on the same edge.
- ERR (an action, not a state):
  - retry_cnt increments on every ERR.
  - If the new value equals MAX_RETRY -> FAIL; otherwise -> RST.
  - timeout_pulse=1 for one cycle when the cause is a timeout.
- FAIL:
  - fail=1, bs_rst=1. Sticky; leaves only via enable=0 or reset.
  - retry_cnt holds at MAX_RETRY.
- Timers:
  - Timer clears on every state entry and saturates at all-ones.
  - Comparison is >=, so the timeout fires on the cycle count == limit.
- Simultaneous events: the condition listed first in each state wins. Example: bs_done and a timeout in the same cycle -> bs_done is taken.
- Reset mid-operation: all outputs return to their reset values asynchronously. bs_rst=1 immediately clears the bitslip block.

Optional Feature:
Macro GTFMAC_BS_SUP_STATS_EN.
- When defined, adds two outputs:
  - lock_loss_cnt [7:0]: increments on each UP->RST transition, saturates at 255, cleared only by reset.
  - last_fail_cause [1:0]: 0 = none, 1 = lock timeout, 2 = correct timeout, 3 = excessive bitslip. Updated on each ERR; cleared on IDLE->RST.
- When not defined, neither port nor its logic exists.

Test Plan:
- Normal 10G bring-up (LOCK_TIMEOUT=1000, RST_CYCLES=16):
  - Stimulus: enable=1; bs_locked rises 50 cycles after bs_rst falls; bs_busy asserted after 3 cycles; bs_done after 40; rx_block_lock high.
  - Required: bs_rst high exactly 16 cycles; bs_correct high from CORRECT entry until bs_done; link_up=1 after LOSS_FILTER=16 cycles of lock; retry_cnt=0.
- 25G path:
  - Stimulus: bs_done=1 with bs_locked=1 in the same cycle in WAIT_LOCK.
  - Required: bs_correct is never asserted; link_up=1 after 16 lock cycles.
- Lock timeout, MAX_RETRY=3, bs_locked held 0:
  - Required: 3 RST cycles; timeout_pulse seen 3 times, each 1000 cycles after bs_rst falls; retry_cnt=3; fail=1; bs_rst=1.
- bs_excessive=1 in WAIT_LOCK:
  - Required: ERR, retry_cnt 0->1, RST re-entered, no timeout_pulse.
- Lock loss in UP:
  - Stimulus: rx_block_lock low for 15 cycles, then 16 cycles.
  - Required: the 15-cycle drop is ignored; the 16-cycle drop -> link_up=0, RST, with lock_loss_cnt=1 when GTFMAC_BS_SUP_STATS_EN is defined.
- Async reset and enable:
  - Stimulus: reset asserted mid-WAIT_DONE.
  - Required: bs_rst=1 and bs_correct=0 immediately; sup_state=0.
  - Stimulus: enable=0 while in FAIL.
  - Required: IDLE next cycle; fail=0.
